// File: rtl/velocity_loop_sequencer.sv
// Velocity PI loop sequencer: a periodic tick launches sample capture, then error,
// integration, P and I products on one shared multiplier, sum and saturation to a 10-bit gain.
module velocity_loop_sequencer #(
   parameter int          UPDATE_DIV = 50000,
   parameter logic [15:0] I_LIMIT    = 16'd8191,
   parameter int          OUT_SHIFT  = 12
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        loop_enable,
   input  logic [15:0] desired_velocity,
   input  logic        vel_valid,
   input  logic [15:0] actual_velocity,
   input  logic [13:0] kp,
   input  logic [13:0] ki,
   output logic [9:0]  output_gain,
   output logic        gain_valid,
   output logic        busy,
   output logic        sample_missed,
   output logic        overrun,
   output logic [2:0]  state_dbg
);

   localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(UPDATE_DIV - 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_SAMPLE = 3'd1,
      ERR         = 3'd2,
      MUL_P       = 3'd3,
      MUL_I       = 3'd4,
      SUM         = 3'd5,
      SAT         = 3'd6
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [15:0]        des_q;
   logic [15:0]        act_q;
   logic signed [15:0] err_q;
   logic signed [16:0] integ_q;
   logic signed [30:0] p_q;
   logic signed [30:0] i_q;
   logic signed [31:0] sum_q;
   logic [9:0]         output_gain_q;
   logic               gain_valid_q;
   logic               sample_missed_q;
   logic               overrun_q;

   logic               tick;
   logic signed [16:0] diff;
   logic signed [15:0] err_d;
   logic signed [17:0] integ_sum;
   logic signed [17:0] lim_pos;
   logic signed [17:0] lim_neg;
   logic signed [16:0] integ_d;
   logic signed [15:0] mul_a;
   logic [13:0]        mul_b;
   logic signed [30:0] mul_a_ext;
   logic signed [30:0] mul_b_ext;
   logic signed [30:0] prod;
   logic signed [31:0] sum_d;
   logic signed [31:0] shifted;
   logic [9:0]         gain_d;

   assign tick = (cnt_q == TICK_LAST);

   // Error and integrator arithmetic carry one guard bit so saturation sees the true value.
   always_comb begin
      diff = $signed({1'b0, des_q}) - $signed({1'b0, act_q});
      err_d = diff[15:0];
      if (diff > 17'sd32767) begin
         err_d = 16'sh7FFF;
      end else if (diff < -17'sd32768) begin
         err_d = 16'sh8000;
      end
      lim_pos = $signed({2'b00, I_LIMIT});
      lim_neg = -lim_pos;
      integ_sum = $signed({integ_q[16], integ_q}) + $signed({{2{err_d[15]}}, err_d});
      integ_d = integ_sum[16:0];
      if (integ_sum > lim_pos) begin
         integ_d = lim_pos[16:0];
      end else if (integ_sum < lim_neg) begin
         integ_d = lim_neg[16:0];
      end
   end

   // The single multiplier is steered to the I-term operands only in MUL_I.
   always_comb begin
      mul_a     = (state_q == MUL_I) ? integ_q[15:0] : err_q;
      mul_b     = (state_q == MUL_I) ? ki : kp;
      mul_a_ext = {{15{mul_a[15]}}, mul_a};
      mul_b_ext = {17'd0, mul_b};
      prod      = mul_a_ext * mul_b_ext;
      sum_d     = $signed({p_q[30], p_q}) + $signed({i_q[30], i_q});
      shifted   = sum_q >>> OUT_SHIFT;
      gain_d    = shifted[9:0];
      if (shifted[31]) begin
         gain_d = 10'd0;
      end else if (shifted > 32'sd1023) begin
         gain_d = 10'd1023;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         des_q           <= '0;
         act_q           <= '0;
         err_q           <= '0;
         integ_q         <= '0;
         p_q             <= '0;
         i_q             <= '0;
         sum_q           <= '0;
         output_gain_q   <= '0;
         gain_valid_q    <= 1'b0;
         sample_missed_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else if (!loop_enable) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         integ_q         <= '0;
         output_gain_q   <= '0;
         gain_valid_q    <= 1'b0;
         sample_missed_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         cnt_q           <= tick ? '0 : cnt_q + CW'(1);
         gain_valid_q    <= 1'b0;
         sample_missed_q <= 1'b0;
         if (tick && state_q != IDLE && state_q != WAIT_SAMPLE) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (tick) begin
                  des_q   <= desired_velocity;
                  state_q <= WAIT_SAMPLE;
               end
            end
            WAIT_SAMPLE: begin
               if (vel_valid) begin
                  act_q   <= actual_velocity;
                  state_q <= ERR;
               end else if (tick) begin
                  sample_missed_q <= 1'b1;
                  state_q         <= ERR;
               end
            end
            ERR: begin
               err_q   <= err_d;
               integ_q <= integ_d;
               state_q <= MUL_P;
            end
            MUL_P: begin
               p_q     <= prod;
               state_q <= MUL_I;
            end
            MUL_I: begin
               i_q     <= prod;
               state_q <= SUM;
            end
            SUM: begin
               sum_q   <= sum_d;
               state_q <= SAT;
            end
            SAT: begin
               output_gain_q <= gain_d;
               gain_valid_q  <= 1'b1;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign output_gain   = output_gain_q;
   assign gain_valid    = gain_valid_q;
   assign sample_missed = sample_missed_q;
   assign overrun       = overrun_q;
   assign busy          = (state_q != IDLE);
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_velocity_loop_sequencer.sv
// Directed bench for velocity_loop_sequencer: one instance with a 16-cycle tick and
// I_LIMIT=1000, a second with a 4-cycle tick for overrun behaviour.
module tb_velocity_loop_sequencer;

   logic        clk;
   logic        reset_n;
   logic        loop_enable;
   logic [15:0] desired_velocity;
   logic        vel_valid;
   logic [15:0] actual_velocity;
   logic [13:0] kp;
   logic [13:0] ki;
   logic [9:0]  output_gain;
   logic        gain_valid;
   logic        busy;
   logic        sample_missed;
   logic        overrun;
   logic [2:0]  state_dbg;

   logic        b_en;
   logic [15:0] b_des;
   logic        b_vv;
   logic [15:0] b_act;
   logic [9:0]  b_gain;
   logic        b_gv;
   logic        b_busy;
   logic        b_sm;
   logic        b_ov;
   logic [2:0]  b_state;

   int compared;
   int mismatched;

   velocity_loop_sequencer #(.UPDATE_DIV(16), .I_LIMIT(16'd1000), .OUT_SHIFT(12)) dut_a (
      .clk(clk), .reset_n(reset_n), .loop_enable(loop_enable),
      .desired_velocity(desired_velocity), .vel_valid(vel_valid),
      .actual_velocity(actual_velocity), .kp(kp), .ki(ki),
      .output_gain(output_gain), .gain_valid(gain_valid), .busy(busy),
      .sample_missed(sample_missed), .overrun(overrun), .state_dbg(state_dbg)
   );

   velocity_loop_sequencer #(.UPDATE_DIV(4), .I_LIMIT(16'd8191), .OUT_SHIFT(12)) dut_b (
      .clk(clk), .reset_n(reset_n), .loop_enable(b_en),
      .desired_velocity(b_des), .vel_valid(b_vv),
      .actual_velocity(b_act), .kp(kp), .ki(ki),
      .output_gain(b_gain), .gain_valid(b_gv), .busy(b_busy),
      .sample_missed(b_sm), .overrun(b_ov), .state_dbg(b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Returns at the falling edge right after the tick that left IDLE.
   task automatic wait_busy(input bit sel_b);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((sel_b ? b_busy : busy) === 1'b1) break;
      end
      check("busy_start", {31'd0, sel_b ? b_busy : busy}, 32'd1);
   endtask

   task automatic update_a(input logic [15:0] des, input logic [15:0] act, input logic [9:0] exp_gain);
      desired_velocity = des;
      wait_busy(1'b0);
      @(negedge clk);
      vel_valid       = 1'b1;
      actual_velocity = act;
      @(negedge clk);
      vel_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("gv_early", {31'd0, gain_valid}, 32'd0);
      end
      @(negedge clk);
      check("gv_pulse", {31'd0, gain_valid}, 32'd1);
      check("gain", {22'd0, output_gain}, {22'd0, exp_gain});
      check("busy_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("gv_drop", {31'd0, gain_valid}, 32'd0);
      check("gain_hold", {22'd0, output_gain}, {22'd0, exp_gain});
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      reset_n = 1'b0;
      loop_enable = 1'b0;
      desired_velocity = '0;
      vel_valid = 1'b0;
      actual_velocity = '0;
      kp = 14'd4096;
      ki = 14'd0;
      b_en = 1'b0;
      b_des = '0;
      b_vv = 1'b0;
      b_act = '0;
      repeat (3) @(negedge clk);
      check("rst_gain", {22'd0, output_gain}, 32'd0);
      check("rst_gv", {31'd0, gain_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sm", {31'd0, sample_missed}, 32'd0);
      check("rst_ov", {31'd0, overrun}, 32'd0);
      check("rst_b_busy", {31'd0, b_busy}, 32'd0);
      reset_n = 1'b1;
      loop_enable = 1'b1;

      // Proportional only: err 100, kp 4096 -> 100.
      update_a(16'd1000, 16'd900, 10'd100);

      loop_enable = 1'b0;
      @(negedge clk);
      check("dis_gain", {22'd0, output_gain}, 32'd0);
      check("dis_busy", {31'd0, busy}, 32'd0);
      loop_enable = 1'b1;

      kp = 14'd16383;
      update_a(16'd32767, 16'd0, 10'd1023);
      update_a(16'd100, 16'd500, 10'd0);

      loop_enable = 1'b0;
      @(negedge clk);
      loop_enable = 1'b1;

      // Integral only with clamp at 1000, then unwinding by -100.
      kp = 14'd0;
      ki = 14'd4096;
      for (int k = 1; k <= 11; k++) begin
         update_a(16'd1100, 16'd1000, (k <= 10) ? 10'(k * 100) : 10'd1000);
      end
      update_a(16'd900, 16'd1000, 10'd900);

      // Sample timeout: the previously latched actual (1000) is reused.
      kp = 14'd4096;
      ki = 14'd0;
      desired_velocity = 16'd1500;
      wait_busy(1'b0);
      repeat (15) @(negedge clk);
      check("sm_before", {31'd0, sample_missed}, 32'd0);
      @(negedge clk);
      check("sm_pulse", {31'd0, sample_missed}, 32'd1);
      check("sm_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("sm_drop", {31'd0, sample_missed}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sm_gv_early", {31'd0, gain_valid}, 32'd0);
      end
      @(negedge clk);
      check("sm_gv", {31'd0, gain_valid}, 32'd1);
      check("sm_gain", {22'd0, output_gain}, 32'd500);

      // Reset while in MUL_I discards the update.
      desired_velocity = 16'd1000;
      wait_busy(1'b0);
      @(negedge clk);
      vel_valid = 1'b1;
      actual_velocity = 16'd900;
      @(negedge clk);
      vel_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_state", {29'd0, state_dbg}, 32'd4);
      check("mid_gain", {22'd0, output_gain}, 32'd500);
      reset_n = 1'b0;
      @(negedge clk);
      check("ra_gain", {22'd0, output_gain}, 32'd0);
      check("ra_gv", {31'd0, gain_valid}, 32'd0);
      check("ra_busy", {31'd0, busy}, 32'd0);
      check("ra_sm", {31'd0, sample_missed}, 32'd0);
      check("ra_ov", {31'd0, overrun}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ra_no_gv", {31'd0, gain_valid}, 32'd0);
      end

      // Fast tick: every update overruns, but each sequence still completes once.
      loop_enable = 1'b0;
      b_des = 16'd1000;
      b_en = 1'b1;
      wait_busy(1'b1);
      @(negedge clk);
      b_vv = 1'b1;
      b_act = 16'd700;
      @(negedge clk);
      b_vv = 1'b0;
      @(negedge clk);
      check("b_ov_before", {31'd0, b_ov}, 32'd0);
      @(negedge clk);
      check("b_ov_set", {31'd0, b_ov}, 32'd1);
      check("b_no_sm", {31'd0, b_sm}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("b_gv_early", {31'd0, b_gv}, 32'd0);
      end
      @(negedge clk);
      check("b_gv1", {31'd0, b_gv}, 32'd1);
      check("b_gain1", {22'd0, b_gain}, 32'd300);
      @(negedge clk);
      check("b_gv1_drop", {31'd0, b_gv}, 32'd0);
      check("b_restart", {31'd0, b_busy}, 32'd1);
      check("b_ov_sticky", {31'd0, b_ov}, 32'd1);
      @(negedge clk);
      b_vv = 1'b1;
      b_act = 16'd800;
      @(negedge clk);
      b_vv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b_gv2_early", {31'd0, b_gv}, 32'd0);
      end
      @(negedge clk);
      check("b_gv2", {31'd0, b_gv}, 32'd1);
      check("b_gain2", {22'd0, b_gain}, 32'd200);
      b_en = 1'b0;
      @(negedge clk);
      check("b_dis_ov", {31'd0, b_ov}, 32'd0);
      check("b_dis_gain", {22'd0, b_gain}, 32'd0);
      check("b_dis_busy", {31'd0, b_busy}, 32'd0);
      check("b_dis_gv", {31'd0, b_gv}, 32'd0);
      b_en = 1'b1;
      wait_busy(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/velocity_loop_sequencer.md
VELOCITY_LOOP_SEQUENCER -- requirements
Module: velocity_loop_sequencer

Interface
REQ-001 Parameter UPDATE_DIV, default 50000: clk cycles per loop-update tick (>=2).
REQ-002 Parameter I_LIMIT, default 16'd8191: integrator clamp magnitude, 1..32767.
REQ-003 Parameter OUT_SHIFT, default 12: arithmetic right shift applied to the PI sum before output saturation.
REQ-004 clk  in  1  sole clock, all logic on posedge.
REQ-005 reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-006 loop_enable  in  1  high runs the loop; low aborts and holds the block idle.
REQ-007 desired_velocity  in  16  unsigned setpoint.
REQ-008 vel_valid  in  1  single-cycle strobe, actual_velocity valid.
REQ-009 actual_velocity  in  16  unsigned measured velocity.
REQ-010 kp, ki  in  14 each  unsigned gains.
REQ-011 output_gain  out  10  unsigned duty-cycle gain, held between updates.
REQ-012 gain_valid  out  1  one-cycle pulse when output_gain updates.
REQ-013 busy  out  1  high whenever FSM is not IDLE.
REQ-014 sample_missed  out  1  one-cycle pulse on sample timeout.
REQ-015 overrun  out  1  sticky; tick arrived during compute.

Function
REQ-016 Tick counter SHALL count 0..UPDATE_DIV-1 and wrap; tick is asserted in the cycle the count equals UPDATE_DIV-1.
REQ-017 FSM states SHALL be IDLE, WAIT_SAMPLE, ERR, MUL_P, MUL_I, SUM, SAT.
REQ-018 IDLE: on tick, latch desired_velocity, go to WAIT_SAMPLE.
REQ-019 WAIT_SAMPLE: vel_valid high -> latch actual_velocity, go to ERR; tick before vel_valid -> pulse sample_missed, keep previous latched actual (0 after reset), go to ERR; vel_valid and tick in the same cycle -> vel_valid wins, no sample_missed.
REQ-020 vel_valid outside WAIT_SAMPLE SHALL be ignored.
REQ-021 ERR: err = desired - actual as 17-bit signed, saturated to 16-bit signed [-32768, 32767]; integ = integ + err, clamped to [-I_LIMIT, +I_LIMIT]; integ is 17-bit signed.
REQ-022 Both products SHALL share one signed(16) x unsigned(14) multiplier; operand mux selects (err, kp) in MUL_P and (integ, ki) in MUL_I; each product is registered as 31-bit signed.
REQ-023 SUM: 32-bit signed sum = p + i.
REQ-024 SAT: v = sum >>> OUT_SHIFT; output_gain = 0 if v < 0, 1023 if v > 1023, else v[9:0]; gain_valid = 1 for this cycle; next state IDLE.
REQ-025 Latency: vel_valid (or timeout tick) sampled at edge N -> output_gain and gain_valid update at edge N+5.
REQ-026 A tick in ERR..SAT SHALL be dropped and SHALL set overrun; it SHALL not restart the sequence.
REQ-027 loop_enable low at any edge SHALL force IDLE, integ = 0, tick counter = 0, output_gain = 0, gain_valid = 0, overrun = 0; an in-flight update is discarded.
REQ-028 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-029 reset_n low at an edge SHALL set state IDLE, tick counter 0, integ 0, latched desired/actual 0, p/i/sum 0, output_gain 0, gain_valid 0, sample_missed 0, overrun 0; reset overrides loop_enable and aborts any update.

Verification
REQ-030 UPDATE_DIV=16, kp=4096, ki=0, desired=1000, actual=900 with vel_valid 2 cycles after tick -> output_gain=100, gain_valid exactly 5 cycles after vel_valid.
REQ-031 kp=16383, ki=0, desired=32767, actual=0 -> output_gain=1023; swap to desired=100, actual=500 -> output_gain=0.
REQ-032 I_LIMIT=1000, kp=0, ki=4096, err=+100 each update -> outputs 100,200,...,1000,1000; then err=-100 -> output 900 on the next update (no windup).
REQ-033 UPDATE_DIV=16, vel_valid never asserted -> sample_missed pulse on 2nd tick, computation uses last latched actual, gain_valid 5 cycles later.
REQ-034 UPDATE_DIV=4, vel_valid 2 cycles after tick -> overrun set, sequence completes once, later ticks resume normally; loop_enable low for 1 cycle -> overrun=0, output_gain=0.
REQ-035 reset_n low during MUL_I -> next cycle all outputs 0, busy=0, no gain_valid pulse from the aborted update.
